// File: rtl/spi_i2c_pkg.sv
// Shared constants and types for the SPI/I2C register bank.
package spi_i2c_pkg;

    localparam logic [2:0] REG_OUT          = 3'd0;
    localparam logic [2:0] REG_STATUS       = 3'd7;
    localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h70;
    localparam logic [7:0] REG_RESET        = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WR_PTR,
        ST_ACK_PTR,
        ST_WR_DATA,
        ST_ACK_DATA,
        ST_RD_DATA,
        ST_RD_ACK
    } i2c_state_t;

    function automatic logic [7:0] status_byte(input logic [3:0] status);
        return {4'h0, status};
    endfunction

endpackage

// File: rtl/i2c_target.sv
// I2C 7-bit target with a persistent register pointer and auto-increment.
module i2c_target
    import spi_i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR    = I2C_ADDR_DEFAULT,
    parameter int unsigned AW          = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          scl,
    input  logic          sda,
    input  logic [7:0]    rdata,
    output logic [AW-1:0] raddr,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          sda_oe
);

    // {scl, sda}
    logic [1:0] sync_q [SYNC_STAGES];
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            sync_q[0] <= {scl, sda};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = sync_q[SYNC_STAGES-1][1];
    assign sda_s    = sync_q[SYNC_STAGES-1][0];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    i2c_state_t    state_q;
    logic [3:0]    cnt_q;
    logic [7:0]    sr_q, tx_q;
    logic [AW-1:0] ptr_q, waddr_q;
    logic          rw_q, ack_q, sda_oe_q, we_q;
    logic [7:0]    wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            tx_q     <= '0;
            ptr_q    <= '0;
            rw_q     <= 1'b0;
            ack_q    <= 1'b0;
            sda_oe_q <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= REG_RESET;
        end else begin
            we_q <= 1'b0;
            if (!en) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
            end else if (start_c) begin
                state_q  <= ST_ADDR;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
            end else if (stop_c) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
            end else begin
                if (scl_rise) begin
                    sr_q  <= {sr_q[6:0], sda_s};
                    cnt_q <= cnt_q + 4'd1;
                end
                // SCL rise and fall are never flagged in the same cycle, so the
                // per-state updates below cannot collide with the shift above
                unique case (state_q)
                    ST_ADDR: if (scl_fall && cnt_q == 4'd8) begin
                        if (sr_q[7:1] == I2C_ADDR) begin
                            sda_oe_q <= 1'b1;
                            rw_q     <= sr_q[0];
                            state_q  <= ST_ACK_ADDR;
                        end else begin
                            state_q  <= ST_IDLE;
                        end
                    end
                    ST_ACK_ADDR: if (scl_fall) begin
                        cnt_q <= '0;
                        if (rw_q) begin
                            tx_q     <= rdata;
                            sda_oe_q <= ~rdata[7];
                            state_q  <= ST_RD_DATA;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_WR_PTR;
                        end
                    end
                    ST_WR_PTR: if (scl_fall && cnt_q == 4'd8) begin
                        ptr_q    <= sr_q[AW-1:0];
                        sda_oe_q <= 1'b1;
                        state_q  <= ST_ACK_PTR;
                    end
                    ST_ACK_PTR, ST_ACK_DATA: if (scl_fall) begin
                        cnt_q    <= '0;
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_WR_DATA;
                    end
                    ST_WR_DATA: if (scl_fall && cnt_q == 4'd8) begin
                        we_q     <= 1'b1;
                        waddr_q  <= ptr_q;
                        wdata_q  <= sr_q;
                        ptr_q    <= ptr_q + 1'b1;
                        sda_oe_q <= 1'b1;
                        state_q  <= ST_ACK_DATA;
                    end
                    ST_RD_DATA: if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_RD_ACK;
                        end else begin
                            tx_q     <= {tx_q[6:0], 1'b0};
                            sda_oe_q <= ~tx_q[6];
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            ack_q <= ~sda_s;
                            if (!sda_s) ptr_q <= ptr_q + 1'b1;
                        end
                        if (scl_fall) begin
                            cnt_q <= '0;
                            if (ack_q) begin
                                tx_q     <= rdata;
                                sda_oe_q <= ~rdata[7];
                                state_q  <= ST_RD_DATA;
                            end else begin
                                state_q  <= ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign raddr  = ptr_q;
    assign we     = we_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign sda_oe = sda_oe_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: one command byte then one data byte per cs_n frame.
module spi_target
    import spi_i2c_pkg::*;
#(
    parameter int unsigned AW          = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cs_n,
    input  logic          sclk,
    input  logic          mosi,
    input  logic [7:0]    rdata,
    output logic [AW-1:0] raddr,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          miso
);

    // {cs_n, sclk, mosi}
    logic [2:0] sync_q [SYNC_STAGES];
    logic       sclk_prev_q;
    logic       cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
            sclk_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {cs_n, sclk, mosi};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = sync_q[SYNC_STAGES-1][2];
    assign sclk_s    = sync_q[SYNC_STAGES-1][1];
    assign mosi_s    = sync_q[SYNC_STAGES-1][0];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    logic [4:0]    cnt_q, cnt_d;
    logic [7:0]    sr_q, sr_d, sr_shift;
    logic [7:0]    tx_q, tx_d;
    logic          is_write_q, is_write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          load_q, load_d;
    logic          miso_q, miso_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;

    always_comb begin
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        tx_d       = tx_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        load_d     = 1'b0;
        miso_d     = miso_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        sr_shift   = {sr_q[6:0], mosi_s};
        if (!en || cs_s) begin
            cnt_d  = '0;
            miso_d = 1'b0;
        end else begin
            if (load_q) begin
                tx_d   = {rdata[6:0], 1'b0};
                miso_d = rdata[7];
            end
            // bit counter saturates at 16 so trailing bytes in the frame are ignored
            if (sclk_rise && cnt_q < 5'd16) begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    is_write_d = sr_shift[7];
                    addr_d     = sr_shift[AW-1:0];
                    load_d     = ~sr_shift[7];
                end
                if (cnt_q == 5'd15 && is_write_q) begin
                    we_d    = 1'b1;
                    wdata_d = sr_shift;
                end
            end
            if (sclk_fall && cnt_q >= 5'd9 && !is_write_q) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            tx_q       <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            load_q     <= 1'b0;
            miso_q     <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= REG_RESET;
        end else begin
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            tx_q       <= tx_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            load_q     <= load_d;
            miso_q     <= miso_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
        end
    end

    assign raddr = addr_q;
    assign waddr = addr_q;
    assign we    = we_q;
    assign wdata = wdata_q;
    assign miso  = miso_q;

endmodule

// File: rtl/spi_i2c_reg_bank.sv
// TinyTapeout register bank shared by an SPI target and an I2C target.
module spi_i2c_reg_bank
    import spi_i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [6:0]  I2C_ADDR    = I2C_ADDR_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned     AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0]   OUT_A    = AW'(REG_OUT);
    localparam logic [AW-1:0]   STATUS_A = AW'(REG_STATUS);

    logic mode_i2c;
    assign mode_i2c = ui_in[0];

    logic [AW-1:0] spi_raddr, spi_waddr, i2c_raddr, i2c_waddr;
    logic [7:0]    spi_rdata, spi_wdata, i2c_rdata, i2c_wdata;
    logic          spi_we, i2c_we, spi_miso, i2c_sda_oe;

    spi_target #(
        .AW          (AW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~mode_i2c),
        .cs_n  (ui_in[1]),
        .sclk  (ui_in[2]),
        .mosi  (ui_in[3]),
        .rdata (spi_rdata),
        .raddr (spi_raddr),
        .we    (spi_we),
        .waddr (spi_waddr),
        .wdata (spi_wdata),
        .miso  (spi_miso)
    );

    i2c_target #(
        .I2C_ADDR    (I2C_ADDR),
        .AW          (AW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_i2c (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (mode_i2c),
        .scl    (uio_in[2]),
        .sda    (uio_in[1]),
        .rdata  (i2c_rdata),
        .raddr  (i2c_raddr),
        .we     (i2c_we),
        .waddr  (i2c_waddr),
        .wdata  (i2c_wdata),
        .sda_oe (i2c_sda_oe)
    );

    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    always_comb begin
        we    = mode_i2c ? i2c_we    : spi_we;
        waddr = mode_i2c ? i2c_waddr : spi_waddr;
        wdata = mode_i2c ? i2c_wdata : spi_wdata;
    end

    // Reads see the registered array, so a same-cycle write returns the old value
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != STATUS_A) regs_d[waddr] = wdata;
        spi_rdata = (spi_raddr == STATUS_A) ? status_byte(ui_in[7:4]) : regs_q[spi_raddr];
        i2c_rdata = (i2c_raddr == STATUS_A) ? status_byte(ui_in[7:4]) : regs_q[i2c_raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign uo_out  = regs_q[OUT_A];
    assign uio_out = {7'b0, spi_miso};
    assign uio_oe  = {6'b0, i2c_sda_oe, 1'b1};

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:3], uio_in[0]};

endmodule

// File: tb/tb_spi_i2c_reg_bank.sv
// Directed bench for spi_i2c_reg_bank: SPI/I2C access, status, mode gating, reset.
module tb_spi_i2c_reg_bank;

    localparam int H = 80;  // SPI half period
    localparam int Q = 40;  // I2C quarter period

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode, cs_n, sclk, mosi;
    logic [3:0] status;
    logic       scl_m, sda_m, sda_line;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~uio_oe[1];
    assign ui_in    = {status, mosi, sclk, cs_n, mode};
    assign uio_in   = {5'b0, scl_m, sda_line, 1'b0};

    spi_i2c_reg_bank #(
        .NUM_REGS    (8),
        .I2C_ADDR    (7'h70),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input int nbits, output logic [7:0] rx);
        logic [15:0] tx;
        tx = {b0, b1};
        rx = 8'h00;
        cs_n = 1'b0;
        #H;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[15-i];
            #H;
            if (i >= 8) rx = {rx[6:0], uio_out[0]};
            sclk = 1'b1;
            #H;
            sclk = 1'b0;
        end
        #H;
        cs_n = 1'b1;
        mosi = 1'b0;
        #(2*H);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic i2c_write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #Q;
            scl_m = 1'b1; #(2*Q);
            scl_m = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = ~sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_read_byte(input logic master_ack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; #Q;
            scl_m = 1'b1; #Q;
            b = {b[6:0], sda_line}; #Q;
            scl_m = 1'b0; #Q;
        end
        sda_m = ~master_ack; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
        sda_m = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] rx;
        rst_n = 1'b0; mode = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        status = 4'h0; scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h expected %h", uo_out, 8'h00); end
        checks++; if (uio_oe !== 8'h01) begin errors++; $display("FAIL reset_uio_oe got %h expected %h", uio_oe, 8'h01); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h expected %h", uio_out, 8'h00); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_frame(8'h03, 8'h00, 16, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reset_spi_rd_reg3 got %h expected %h", rx, 8'h00); end
    endtask

    task automatic test_spi_write();
        logic [7:0] rx;
        @(negedge clk);
        spi_frame(8'h80, 8'hA5, 16, rx);
        checks++; if (uo_out !== 8'hA5) begin errors++; $display("FAIL spi_wr_reg0 got %h expected %h", uo_out, 8'hA5); end
        spi_frame(8'h00, 8'h00, 16, rx);
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL spi_rd_reg0 got %h expected %h", rx, 8'hA5); end
        spi_frame(8'h83, 8'h5E, 16, rx);
        spi_frame(8'h03, 8'h00, 16, rx);
        checks++; if (rx !== 8'h5E) begin errors++; $display("FAIL spi_rd_reg3 got %h expected %h", rx, 8'h5E); end
        spi_frame(8'h84, 8'hFF, 12, rx);
        spi_frame(8'h04, 8'h00, 16, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL spi_abort_reg4 got %h expected %h", rx, 8'h00); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL spi_miso_idle got %h expected %h", uio_out, 8'h00); end
    endtask

    task automatic test_spi_status();
        logic [7:0] rx;
        @(negedge clk);
        status = 4'hC;
        spi_frame(8'h07, 8'h00, 16, rx);
        checks++; if (rx !== 8'h0C) begin errors++; $display("FAIL spi_status_c got %h expected %h", rx, 8'h0C); end
        spi_frame(8'h87, 8'hFF, 16, rx);
        spi_frame(8'h07, 8'h00, 16, rx);
        checks++; if (rx !== 8'h0C) begin errors++; $display("FAIL spi_status_ro got %h expected %h", rx, 8'h0C); end
        status = 4'h3;
        spi_frame(8'h07, 8'h00, 16, rx);
        checks++; if (rx !== 8'h03) begin errors++; $display("FAIL spi_status_3 got %h expected %h", rx, 8'h03); end
    endtask

    task automatic test_i2c_write();
        logic ack;
        logic [7:0] bytes [4];
        bytes = '{8'hE0, 8'h01, 8'h3C, 8'h5A};
        @(negedge clk);
        mode = 1'b1;
        repeat (10) @(negedge clk);
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            i2c_write_byte(bytes[i], ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL i2c_wr_ack%0d got %b expected %b", i, ack, 1'b1); end
        end
        i2c_stop();
        repeat (10) @(negedge clk);
        checks++; if (uo_out !== 8'hA5) begin errors++; $display("FAIL i2c_wr_reg0_kept got %h expected %h", uo_out, 8'hA5); end
    endtask

    task automatic test_i2c_read();
        logic ack;
        logic [7:0] b;
        @(negedge clk);
        i2c_start();
        i2c_write_byte(8'hE0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL i2c_rd_ack_addr got %b expected %b", ack, 1'b1); end
        i2c_write_byte(8'h01, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL i2c_rd_ack_ptr got %b expected %b", ack, 1'b1); end
        i2c_start();
        i2c_write_byte(8'hE1, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL i2c_rd_ack_raddr got %b expected %b", ack, 1'b1); end
        i2c_read_byte(1'b1, b);
        checks++; if (b !== 8'h3C) begin errors++; $display("FAIL i2c_rd_byte0 got %h expected %h", b, 8'h3C); end
        i2c_read_byte(1'b0, b);
        checks++; if (b !== 8'h5A) begin errors++; $display("FAIL i2c_rd_byte1 got %h expected %h", b, 8'h5A); end
        i2c_stop();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_i2c_wrong_addr();
        logic ack;
        logic [7:0] b;
        @(negedge clk);
        i2c_start();
        i2c_write_byte(8'hE2, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL i2c_bad_addr_ack got %b expected %b", ack, 1'b0); end
        i2c_write_byte(8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL i2c_bad_ptr_ack got %b expected %b", ack, 1'b0); end
        i2c_write_byte(8'h99, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL i2c_bad_data_ack got %b expected %b", ack, 1'b0); end
        i2c_stop();
        repeat (10) @(negedge clk);
        checks++; if (uo_out !== 8'hA5) begin errors++; $display("FAIL i2c_bad_reg0 got %h expected %h", uo_out, 8'hA5); end
        // pointer left at 2 by the previous NACKed read
        i2c_start();
        i2c_write_byte(8'hE1, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL i2c_ptr_ack got %b expected %b", ack, 1'b1); end
        i2c_read_byte(1'b0, b);
        checks++; if (b !== 8'h5A) begin errors++; $display("FAIL i2c_ptr_persist got %h expected %h", b, 8'h5A); end
        i2c_stop();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode_ignore();
        logic ack;
        logic [7:0] rx;
        @(negedge clk);
        mode = 1'b0;
        repeat (10) @(negedge clk);
        i2c_start();
        i2c_write_byte(8'hE0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mode_i2c_addr_ack got %b expected %b", ack, 1'b0); end
        i2c_write_byte(8'h00, ack);
        i2c_write_byte(8'h77, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mode_i2c_data_ack got %b expected %b", ack, 1'b0); end
        i2c_stop();
        repeat (10) @(negedge clk);
        checks++; if (uo_out !== 8'hA5) begin errors++; $display("FAIL mode_i2c_reg0 got %h expected %h", uo_out, 8'hA5); end
        mode = 1'b1;
        repeat (10) @(negedge clk);
        spi_frame(8'h80, 8'h11, 16, rx);
        checks++; if (uo_out !== 8'hA5) begin errors++; $display("FAIL mode_spi_reg0 got %h expected %h", uo_out, 8'hA5); end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic [7:0] b, rx, data;
        data = 8'h96;
        @(negedge clk);
        mode = 1'b1;
        repeat (10) @(negedge clk);
        i2c_start();
        i2c_write_byte(8'hE0, ack);
        i2c_write_byte(8'h01, ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = data[i]; #Q;
            scl_m = 1'b1; #(2*Q);
            scl_m = 1'b0; #Q;
        end
        sda_m = 1'b1;
        checks++; if (uio_oe[1] !== 1'b1) begin errors++; $display("FAIL mid_ack_pull got %b expected %b", uio_oe[1], 1'b1); end
        rst_n = 1'b0;
        #1;
        checks++; if (uio_oe !== 8'h01) begin errors++; $display("FAIL mid_rst_oe got %h expected %h", uio_oe, 8'h01); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL mid_rst_uo got %h expected %h", uo_out, 8'h00); end
        @(negedge clk);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b0;
        repeat (5) @(negedge clk);
        spi_frame(8'h01, 8'h00, 16, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL mid_rst_reg1 got %h expected %h", rx, 8'h00); end
        spi_frame(8'h80, 8'h42, 16, rx);
        spi_frame(8'h81, 8'h24, 16, rx);
        mode = 1'b1;
        repeat (10) @(negedge clk);
        i2c_start();
        i2c_write_byte(8'hE1, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_post_rd_ack got %b expected %b", ack, 1'b1); end
        i2c_read_byte(1'b0, b);
        checks++; if (b !== 8'h42) begin errors++; $display("FAIL mid_ptr_cleared got %h expected %h", b, 8'h42); end
        i2c_stop();
        i2c_start();
        i2c_write_byte(8'hE0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_post_wr_ack0 got %b expected %b", ack, 1'b1); end
        i2c_write_byte(8'h00, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_post_wr_ack1 got %b expected %b", ack, 1'b1); end
        i2c_write_byte(8'h11, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_post_wr_ack2 got %b expected %b", ack, 1'b1); end
        i2c_stop();
        repeat (10) @(negedge clk);
        checks++; if (uo_out !== 8'h11) begin errors++; $display("FAIL mid_post_reg0 got %h expected %h", uo_out, 8'h11); end
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_spi_status();
        test_i2c_write();
        test_i2c_read();
        test_i2c_wrong_addr();
        test_mode_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_i2c_reg_bank.md
Name: spi_i2c_reg_bank

Overview:
- TinyTapeout user block: an 8x8-bit register bank reachable from either an SPI target or an I2C target.
- ui_in[0] selects the active interface; the other interface is held idle.
- Register 0 drives uo_out directly.
- Register 7 is a read-only status register mirroring ui_in[7:4].

Parameters:
- NUM_REGS, 8: register count; address width = clog2(NUM_REGS) = 3.
- I2C_ADDR, 7'h70: 7-bit I2C target address.
- SYNC_STAGES, 2: flip-flop synchronizer depth on all serial inputs.

Ports:
- clk  in  1  system clock; must run at least 8x the SPI SCLK and I2C SCL rates.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design-selected indication; ignored.
- ui_in  in  8  [0] mode (0=SPI, 1=I2C); [1] spi_cs_n; [2] spi_sclk; [3] spi_mosi; [7:4] status inputs.
- uo_out  out  8  contents of register 0.
- uio_in  in  8  [1] i2c SDA in; [2] i2c SCL in; others unused.
- uio_out  out  8  [0] spi_miso; [1] constant 0 (open-drain SDA); others 0.
- uio_oe  out  8  [0]=1; [1]=1 only while pulling SDA low; others 0.

Behaviour:
- Reset: all registers 0x00, uo_out=0x00, uio_out=0x00, uio_oe=0x01. Both FSMs return to IDLE and the I2C pointer clears to 0.
- Every serial input passes through a SYNC_STAGES synchronizer. Edges are detected in the clk domain from the last two synchronized samples.
- Registers 0-6 are read/write. Register 7 reads {4'h0, ui_in[7:4]}, sampled at read time; writes to it are ignored.
- Mode:
  - Only the interface selected by ui_in[0] may write.
  - The deselected FSM is forced to IDLE; its MISO/SDA outputs are released (MISO=0, SDA oe=0).
- SPI target (mode 0, CPOL=0 CPHA=0, MSB first):
  - cs_n high forces IDLE, clears the bit counter and sets MISO=0.
  - Sampling: MOSI is sampled on synchronized SCLK rising edges. MISO updates on falling edges.
  - Command byte: bit7 = 1 write / 0 read; bits[2:0] = address; bits[6:3] ignored.
  - Write: the second byte is committed to reg[addr] in the clk cycle after its 8th rising edge.
  - Read: reg[addr] is loaded into the shift register after the 8th command bit. Its MSB is on MISO before the 9th rising edge.
  - Further bytes in the same cs_n frame are ignored. cs_n rising mid-byte aborts without a write.
- I2C target (7-bit addressing, standard/fast mode):
  - START/repeated START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Either aborts the current byte and resets the bit counter.
  - FSM states: IDLE, ADDR, ACK_ADDR, WR_PTR, ACK_PTR, WR_DATA, ACK_DATA, RD_DATA, RD_ACK.
  - Address byte equal to I2C_ADDR: ACK by pulling SDA low from the 8th SCL falling edge to the 9th SCL falling edge. Any other address: no ACK, FSM waits for START/STOP.
  - Write (R/W=0):
    - First data byte sets the pointer (bits[2:0]).
    - Each subsequent byte writes reg[ptr] and is ACKed; ptr then increments, wrapping 7 to 0.
  - Read (R/W=1):
    - Shifts reg[ptr] out MSB first; SDA changes only while SCL is low.
    - Master ACK: ptr increments and the next byte is loaded. Master NACK: FSM goes IDLE.
  - The pointer persists across transactions until reset.
- Simultaneous events: a write and a read of the same register in one clk cycle return the old value. START overrides any in-progress state.

Decomposition:
- Package spi_i2c_pkg holds: register address constants (REG_OUT=0, REG_STATUS=7), I2C_ADDR default, the reset value, and the I2C FSM state enum.
- Sub-modules: spi_target and i2c_target, each producing a (we, addr, wdata) write port and a read address.
- The top level holds the reg file, the mode mux and the TinyTapeout pin mapping.

Test Plan:
- Reset: after reset -> uo_out=0x00, uio_oe=0x01; an SPI read of reg3 returns 0x00.
- SPI write: mode=0, frame 0x80,0xA5 -> uo_out=0xA5. Then frame 0x00,0x00 -> MISO returns 0xA5.
- SPI status read: ui_in[7:4]=0xC, frame 0x07,0x00 -> MISO=0x0C. Frame 0x87,0xFF -> reg7 unchanged.
- I2C write then read: mode=1.
  - START, 0xE0, 0x01, 0x3C, 0x5A, STOP -> ACK on every byte.
  - START, 0xE0, 0x01, Sr, 0xE1, read 2 bytes (ACK, then NACK) -> 0x3C, 0x5A.
- I2C wrong address: START, 0xE2, ... -> SDA high on the 9th clock and no register change. I2C traffic while mode=0 -> ignored.
- Reset mid-transaction: rst_n low during an I2C data byte -> SDA released immediately, all registers 0x00, next transaction is normal.
